move_list_sequencer: RTL
========================

Name: move_list_sequencer

Overview:
- Sequencer and reader for the 64-cell square array.
- Accepts a move-generation request (source square, piece type) from software.
- Drives the array's init, square_calc and piece_type_calc broadcast inputs, then waits a fixed settle time for ray propagation.
- Captures the 64 movebit outputs and streams each legal destination square to software over a valid/ready handshake, in ascending square order.

Parameters:
- SETTLE_CYCLES, 4, cycles that init is held low before movebits are captured; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- req_square  in  6  source square; id = rank*8 + file; white pawns advance toward higher ids
- req_piece  in  4  piece type enum: 0 BROOK, 1 BBISHOP, 2 BKNIGHT, 3 BQUEEN, 4 BKING, 5 BPAWN, 6 WROOK, 7 WBISHOP, 8 WKNIGHT, 9 WQUEEN, 10 WKING, 11 WPAWN
- movebits  in  64  bit i = movebit output of square i
- occupancy  in  64  bit i = square i occupied; used only by the optional feature
- init  out  1  broadcast init to all squares
- square_calc  out  6  broadcast source square
- piece_type_calc  out  4  broadcast piece type
- busy  out  1  high in any state except IDLE
- move_valid  out  1  move_dst is valid
- move_dst  out  6  destination square
- move_ready  in  1  consumer accepts move_dst
- done  out  1  one-cycle pulse at end of list
- move_count  out  7  number of moves handed off for the last request (0..64)

Behaviour:
- Reset values: init=1, square_calc=0, piece_type_calc=0, busy=0, move_valid=0, move_dst=0, done=0, move_count=0. Internal state is IDLE, pending=0, settle counter=0.
- Reset asserted mid-operation aborts immediately to these values. No partial done pulse is issued.
- IDLE:
  - init=1.
  - start=1 registers req_square into square_calc and req_piece into piece_type_calc, clears move_count and loads the settle counter. Next state is SETTLE.
- SETTLE:
  - init=0; the counter decrements each cycle.
  - The array sees init low for exactly SETTLE_CYCLES cycles.
  - On the last SETTLE cycle, pending <= movebits with bit square_calc forced to 0. Next state is SCAN.
- SCAN:
  - move_valid = (pending != 0); move_dst = index of the lowest set bit of pending, driven combinationally from the pending register.
  - Handshake on move_valid & move_ready: clear that bit, increment move_count.
  - move_dst and move_valid stay stable while move_ready is low.
  - If pending == 0, move_valid=0 and next state is DONE. This includes the zero-move case.
- DONE:
  - done=1 for one cycle; next state is IDLE.
  - move_count, square_calc and piece_type_calc hold until the next accepted start.
- start outside IDLE is ignored (no queueing). start in the same cycle as DONE is also ignored.
- Pieces 12..15: request proceeds normally. Captured bits are streamed without interpretation.
- Latency (no backpressure): start at cycle T, first move_valid at T+SETTLE_CYCLES+1, done at T+SETTLE_CYCLES+1+N+1 for N moves.
- move_ready while move_valid=0 has no effect.

Optional Feature:
- PAWN_DOUBLE_EN defined: at capture, the pawn double-step bit is ORed into pending.
  - WPAWN with square_calc in 8..15: adds bit s+16 if movebits[s+8]=1, occupancy[s+8]=0 and occupancy[s+16]=0.
  - BPAWN with square_calc in 48..55: adds bit s-16 under the mirrored conditions.
- PAWN_DOUBLE_EN undefined: pending is exactly the masked movebits and the occupancy input is unused.

Test Plan:
- WROOK, req_square=0; movebits = bits 1..7 and 8,16,..,56; move_ready=1 → move_dst 1,2,...,7,8,16,24,...,56 on consecutive cycles; done once; move_count=14.
- WKNIGHT, req_square=27; movebits = {10,12,17,21,33,37,42,44} plus bit 27 → 8 moves in ascending order; 27 never emitted; move_count=8.
- Zero moves (movebits=0) → no move_valid; done at T+SETTLE_CYCLES+2; move_count=0.
- Backpressure: move_ready low for 5 cycles on the first move → move_dst stable and move_valid held; start pulsed during SCAN is ignored; later moves follow unchanged.
- rst_n low in the middle of SCAN → all outputs return to reset values immediately (init=1). A fresh start afterwards yields a complete list.
- PAWN_DOUBLE_EN, WPAWN at 12; movebits={20}; occupancy={12} → moves 20 and 28, move_count=2. Same test with occupancy bit 28 set → only 20. Same test without the macro → only 20.

Source files
------------

// File: rtl/move_list_sequencer.sv
// Sequencer/reader for the 64-cell square array: broadcasts a request, waits for
// ray settle, then streams legal destinations in ascending order. Option: PAWN_DOUBLE_EN.
module move_list_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  req_square,
  input  logic [3:0]  req_piece,
  input  logic [63:0] movebits,
  input  logic [63:0] occupancy,
  output logic        init,
  output logic [5:0]  square_calc,
  output logic [3:0]  piece_type_calc,
  output logic        busy,
  output logic        move_valid,
  output logic [5:0]  move_dst,
  input  logic        move_ready,
  output logic        done,
  output logic [6:0]  move_count
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SCAN, S_DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  settle_cnt;
  logic [63:0] pending;
  logic [63:0] capture_bits;
  logic [5:0]  lowest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_SETTLE;
      S_SETTLE: if (settle_cnt == 4'd1) state_next = S_SCAN;
      S_SCAN:   if (pending == '0) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign init       = (state != S_SETTLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign move_valid = (state == S_SCAN) && (pending != '0);
  assign move_dst   = lowest;

  // The source square never reports itself as a destination.
  always_comb begin
    capture_bits = movebits;
    capture_bits[square_calc] = 1'b0;
`ifdef PAWN_DOUBLE_EN
    if (piece_type_calc == 4'd11 && square_calc[5:3] == 3'd1 &&
        movebits[square_calc + 6'd8] && !occupancy[square_calc + 6'd8] &&
        !occupancy[square_calc + 6'd16])
      capture_bits[square_calc + 6'd16] = 1'b1;
    if (piece_type_calc == 4'd5 && square_calc[5:3] == 3'd6 &&
        movebits[square_calc - 6'd8] && !occupancy[square_calc - 6'd8] &&
        !occupancy[square_calc - 6'd16])
      capture_bits[square_calc - 6'd16] = 1'b1;
`endif
  end

`ifndef PAWN_DOUBLE_EN
  logic unused_occupancy;
  assign unused_occupancy = ^occupancy;
`endif

  // Descending scan so the lowest set bit wins.
  always_comb begin
    lowest = '0;
    for (int i = 63; i >= 0; i--) begin
      if (pending[i]) lowest = 6'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      square_calc     <= '0;
      piece_type_calc <= '0;
      settle_cnt      <= '0;
      pending         <= '0;
      move_count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            square_calc     <= req_square;
            piece_type_calc <= req_piece;
            move_count      <= '0;
            settle_cnt      <= 4'(SETTLE_CYCLES);
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) pending <= capture_bits;
        end
        S_SCAN: begin
          if (move_valid && move_ready) begin
            pending[lowest] <= 1'b0;
            move_count      <= move_count + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
